// File: rtl/cordic_rr_arbiter.sv
// Round-robin share of one pipelined cordic_rotator between two requesters.
// Issue tags ride a latency-matched shift register to route results home.
module cordic_rr_arbiter #(
  parameter int LATENCY = 16,
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int IW = $clog2(LATENCY+3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_vld,
  output logic          req0_rdy,
  input  logic [AW-1:0] req0_angle,
  input  logic [DW-1:0] req0_xin,
  input  logic [DW-1:0] req0_yin,
  input  logic          req1_vld,
  output logic          req1_rdy,
  input  logic [AW-1:0] req1_angle,
  input  logic [DW-1:0] req1_xin,
  input  logic [DW-1:0] req1_yin,
  output logic [AW-1:0] cor_angle,
  output logic [DW-1:0] cor_xin,
  output logic [DW-1:0] cor_yin,
  input  logic [DW:0]   cor_xout,
  input  logic [DW:0]   cor_yout,
  output logic          res0_vld,
  output logic          res1_vld,
  output logic [DW:0]   res_x,
  output logic [DW:0]   res_y,
  output logic          busy,
  output logic [IW-1:0] inflight
);

  logic           ptr;
  logic           gnt0;
  logic           gnt1;
  logic           hs;
  logic           ret;
  logic [LATENCY:0] tv;
  logic [LATENCY:0] tid;
  logic [IW-1:0]  inflight_nxt;

  // Grant decode: a lone requester wins, a tie goes to the pointer owner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case ({req1_vld, req0_vld})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end
      default: ;
    endcase
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;
  assign hs = gnt0 | gnt1;
  assign ret = res0_vld | res1_vld;

  // Occupancy next-state: one in per handshake, one out per result pulse.
  always_comb begin
    inflight_nxt = inflight + IW'(hs) - IW'(ret);
  end

  // Priority pointer hands over to the other requester after any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (hs) begin
      ptr <= gnt0;
    end
  end

  // Rotator operand registers load only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cor_angle <= '0;
      cor_xin   <= '0;
      cor_yin   <= '0;
    end else if (gnt0) begin
      cor_angle <= req0_angle;
      cor_xin   <= req0_xin;
      cor_yin   <= req0_yin;
    end else if (gnt1) begin
      cor_angle <= req1_angle;
      cor_xin   <= req1_xin;
      cor_yin   <= req1_yin;
    end
  end

  // Tag shift register, LATENCY+1 deep, aligned to the rotator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tv  <= '0;
      tid <= '0;
    end else begin
      tv  <= {tv[LATENCY-1:0], hs};
      tid <= {tid[LATENCY-1:0], gnt1};
    end
  end

  // Result capture and owner pulses from the aligned tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_x    <= '0;
      res_y    <= '0;
      res0_vld <= 1'b0;
      res1_vld <= 1'b0;
    end else begin
      res_x    <= cor_xout;
      res_y    <= cor_yout;
      res0_vld <= tv[LATENCY] & ~tid[LATENCY];
      res1_vld <= tv[LATENCY] & tid[LATENCY];
    end
  end

  // Occupancy counter and its registered non-zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      busy     <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      busy     <= (inflight_nxt != '0);
    end
  end

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a stub latency-matched rotator.
// Result routing is scoreboarded; timing points are hand-derived.
module tb_cordic_rr_arbiter;
  localparam int L = 16;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int IW = $clog2(L+3);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_vld = 1'b0;
  logic req1_vld = 1'b0;
  logic req0_rdy, req1_rdy;
  logic [AW-1:0] req0_angle = '0;
  logic [AW-1:0] req1_angle = '0;
  logic [DW-1:0] req0_xin = '0, req0_yin = '0;
  logic [DW-1:0] req1_xin = '0, req1_yin = '0;
  logic [AW-1:0] cor_angle;
  logic [DW-1:0] cor_xin, cor_yin;
  logic [DW:0] cor_xout, cor_yout;
  logic res0_vld, res1_vld, busy;
  logic [DW:0] res_x, res_y;
  logic [IW-1:0] inflight;

  int errs = 0;
  int checks = 0;
  logic [31:0] cyc = '0;

  cordic_rr_arbiter #(.LATENCY(L), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy),
    .req0_angle(req0_angle), .req0_xin(req0_xin),
    .req0_yin(req0_yin),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy),
    .req1_angle(req1_angle), .req1_xin(req1_xin),
    .req1_yin(req1_yin),
    .cor_angle(cor_angle), .cor_xin(cor_xin),
    .cor_yin(cor_yin),
    .cor_xout(cor_xout), .cor_yout(cor_yout),
    .res0_vld(res0_vld), .res1_vld(res1_vld),
    .res_x(res_x), .res_y(res_y),
    .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW:0] fx(logic [AW-1:0] a,
                                     logic [DW-1:0] x);
    return {x[DW-1], x} + a[AW-1:AW-DW-1];
  endfunction

  function automatic logic [DW:0] fy(logic [AW-1:0] a,
                                     logic [DW-1:0] y);
    return {y[DW-1], y} - a[AW-1:AW-DW-1];
  endfunction

  logic [DW:0] px [L];
  logic [DW:0] py [L];

  always @(posedge clk) begin
    px[0] <= fx(cor_angle, cor_xin);
    py[0] <= fy(cor_angle, cor_yin);
    for (int i = 1; i < L; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end

  assign cor_xout = px[L-1];
  assign cor_yout = py[L-1];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic          id;
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [31:0]   t;
  } op_t;

  op_t sb [$];

  always @(negedge clk) begin
    op_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (req0_vld && req0_rdy)
        sb.push_back({1'b0, req0_angle, req0_xin, req0_yin, cyc});
      if (req1_vld && req1_rdy)
        sb.push_back({1'b1, req1_angle, req1_xin, req1_yin, cyc});
      if (res0_vld || res1_vld) begin
        check("res_onehot", 64'(res0_vld & res1_vld), 0);
        if (sb.size() == 0) begin
          check("res_spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_owner", 64'(res1_vld), 64'(e.id));
          check("res_x", 64'(res_x), 64'(fx(e.a, e.x)));
          check("res_y", 64'(res_y), 64'(fy(e.a, e.y)));
          check("res_lat", 64'(cyc - e.t), L + 2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int peak, n0, n1, grants, first, last;
  logic [AW-1:0] ha;
  logic [DW-1:0] hx, hy;

  initial begin
    #1;
    do_reset();
    @(negedge clk);
    check("rst_inflight", 64'(inflight), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_cor", 64'(cor_angle), 0);
    check("rst_res", 64'({res0_vld, res1_vld, res_x}), 0);

    // single issue from requester 0
    for (int k = 0; k < 9; k++) step();
    req0_vld = 1'b1;
    req0_angle = 32'h2000_0000;
    req0_xin = 16'h4000;
    req0_yin = 16'h0000;
    @(negedge clk);
    check("s_rdy0", 64'(req0_rdy), 1);
    check("s_rdy1", 64'(req1_rdy), 0);
    step();
    req0_vld = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) check("s_cor", 64'(cor_angle), 64'h2000_0000);
      if (res0_vld) n0++;
      if (res1_vld) n1++;
      if (k == L + 2) begin
        check("s_vld18", 64'(res0_vld), 1);
        check("s_rx", 64'(res_x), 64'h0_8000);
        check("s_ry", 64'(res_y), 64'h1_C000);
      end
      check("s_infl", 64'(inflight), (k <= L + 2) ? 1 : 0);
      step();
    end
    check("s_n0", 64'(n0), 1);
    check("s_n1", 64'(n1), 0);

    // contention from reset
    do_reset();
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    peak = 0;
    for (int k = 0; k < 30; k++) begin
      req0_angle = 32'h1000_0000 + 32'(k);
      req0_xin = 16'(k + 1);
      req1_angle = 32'h3000_0000 + 32'(k);
      req1_yin = 16'(k + 7);
      @(negedge clk);
      if (k < 8) begin
        check("c_rdy0", 64'(req0_rdy), 64'((k % 2) == 0));
        check("c_rdy1", 64'(req1_rdy), 64'((k % 2) == 1));
      end
      check("c_res0", 64'(res0_vld),
            64'(k >= 18 && k < 26 && (k % 2) == 0));
      check("c_res1", 64'(res1_vld),
            64'(k >= 18 && k < 26 && (k % 2) == 1));
      if (int'(inflight) > peak) peak = int'(inflight);
      step();
      if (k == 7) begin
        req0_vld = 1'b0;
        req1_vld = 1'b0;
      end
    end
    check("c_peak", 64'(peak), 8);

    // priority handoff
    do_reset();
    req1_vld = 1'b1;
    @(negedge clk);
    check("h_rdy1", 64'(req1_rdy), 1);
    step();
    req0_vld = 1'b1;
    @(negedge clk);
    check("h_rdy0", 64'(req0_rdy), 1);
    check("h_rdy1b", 64'(req1_rdy), 0);
    step();
    @(negedge clk);
    check("h_rdy1c", 64'(req1_rdy), 1);
    step();
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    for (int k = 0; k < 22; k++) step();
    check("h_drain", 64'(inflight), 0);

    // streaming requester 0
    do_reset();
    grants = 0;
    n0 = 0;
    first = -1;
    last = -1;
    peak = 0;
    for (int k = 0; k < 65; k++) begin
      req0_vld = (k < 40);
      req0_angle = 32'(k) << 24;
      req0_xin = 16'(3 * k);
      req0_yin = 16'(100 - k);
      @(negedge clk);
      if (req0_rdy) grants++;
      if (res0_vld) begin
        n0++;
        if (first < 0) first = k;
        last = k;
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      step();
    end
    req0_vld = 1'b0;
    check("st_grants", 64'(grants), 40);
    check("st_results", 64'(n0), 40);
    check("st_first", 64'(first), L + 2);
    check("st_last", 64'(last), L + 2 + 39);
    check("st_peak", 64'(peak), L + 2);

    // reset while operations are in flight
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req0_vld = 1'b1;
      req0_angle = 32'h0500_0000 + 32'(k);
      step();
    end
    req0_vld = 1'b0;
    step();
    step();
    @(negedge clk);
    check("r_pre", 64'(inflight), 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("r_infl", 64'(inflight), 0);
    check("r_busy", 64'(busy), 0);
    check("r_cor", 64'(cor_angle), 0);
    n0 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res0_vld || res1_vld) n0++;
      step();
    end
    check("r_nores", 64'(n0), 0);
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    @(negedge clk);
    check("r_prio", 64'({req1_rdy, req0_rdy}), 64'b01);
    step();
    req0_vld = 1'b0;
    req1_vld = 1'b0;

    // idle hold after a single requester 1 issue
    do_reset();
    req1_vld = 1'b1;
    req1_angle = 32'h0ABC_0000;
    req1_xin = 16'h1234;
    req1_yin = 16'h0F0F;
    step();
    req1_vld = 1'b0;
    ha = 32'h0ABC_0000;
    hx = 16'h1234;
    hy = 16'h0F0F;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (res0_vld) n0++;
      if (res1_vld) n1++;
      step();
    end
    check("i_cora", 64'(cor_angle), 64'(ha));
    check("i_corx", 64'({cor_xin, cor_yin}), 64'({hx, hy}));
    check("i_n1", 64'(n1), 1);
    check("i_n0", 64'(n0), 0);
    check("i_busy", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cordic_rr_arbiter.md
Name: cordic_rr_arbiter

Overview:
- Shares one pipelined cordic_rotator between two requesters using a round-robin valid/ready issue port.
- Tags every issued operation, delays the tag through a shift register matched to the rotator latency, and routes each result back to its owner.
- Sits between the requesters (sweep generators, VIO-driven test logic) and the cordic_rotator instance; all ports are in the one clk domain.

Parameters:
- LATENCY, 16, clock cycles from cordic_rotator input sample to valid Xout/Yout; must be >= 1.
- AW, 32, angle width; matches cordic_rotator angle.
- DW, 16, Xin/Yin width; result width is DW+1.

Ports:
- clk  in  1  system clock; the codebase's clock name.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req0_vld  in  1  requester 0 has an operation.
- req0_rdy  out  1  arbiter accepts requester 0 this cycle.
- req0_angle  in  AW  requester 0 angle.
- req0_xin  in  DW  requester 0 Xin.
- req0_yin  in  DW  requester 0 Yin.
- req1_vld, req1_rdy, req1_angle, req1_xin, req1_yin: same as requester 0, for requester 1.
- cor_angle  out  AW  to cordic_rotator angle, registered.
- cor_xin  out  DW  to cordic_rotator Xin, registered.
- cor_yin  out  DW  to cordic_rotator Yin, registered.
- cor_xout  in  DW+1  from cordic_rotator Xout.
- cor_yout  in  DW+1  from cordic_rotator Yout.
- res0_vld  out  1  one-cycle pulse: result for requester 0.
- res1_vld  out  1  one-cycle pulse: result for requester 1.
- res_x  out  DW+1  registered Xout, shared by both requesters.
- res_y  out  DW+1  registered Yout, shared by both requesters.
- busy  out  1  at least one operation in flight.
- inflight  out  $clog2(LATENCY+3)  count of operations issued and not yet returned.

Behaviour:
- Reset: every output register clears to 0 (cor_*, res_*, res*_vld, busy, inflight). The tag pipeline clears to all-invalid. The round-robin pointer clears to "requester 0 has priority". Any operation in flight when rst is asserted is dropped; no res*_vld pulse may follow it.
- Arbitration is combinational within the cycle; at most one grant per cycle.
  - Only one vld high: that requester gets rdy.
  - Both vld high: the requester with priority gets rdy.
  - After any grant, priority passes to the other requester.
  - rdy is never asserted without its own vld.
  - rdy does not depend on res_* or on the pipeline state. The issue rate is one per cycle, sustained.
- Issue: a handshake (vld & rdy) in cycle t loads cor_angle/cor_xin/cor_yin at edge t+1. The tag pipeline stage 0 loads {valid=1, id=requester}.
  - With no handshake, cor_* hold their previous values and a {valid=0} tag is inserted.
- Tag pipeline: LATENCY+1 stages, so each tag aligns with cor_xout/cor_yout being registered into res_x/res_y.
- Result: res_x/res_y load cor_xout/cor_yout every cycle. resN_vld is high for one cycle when the aligned tag is valid with id=N.
  - End-to-end latency: handshake in cycle t gives resN_vld high in cycle t+LATENCY+2.
  - Back-to-back issues give back-to-back results, in issue order.
- Counters:
  - inflight increments on a handshake and decrements on any res*_vld.
  - Issue and return in the same cycle leave inflight unchanged.
  - Maximum value is LATENCY+2; wrap-around is not possible.
  - busy = (inflight != 0), registered.
- Input values are not checked; arithmetic is the rotator's own. The arbiter does not modify data widths or signs.

Test Plan:
- Single issue: req0_vld=1 for one cycle at cycle 10 with angle=0x20000000, xin=0x4000, yin=0, LATENCY=16 -> req0_rdy=1 at cycle 10; res0_vld=1 only at cycle 28; res_x/res_y match the golden rotator model; res1_vld stays 0; inflight is 1 during cycles 11..28 and 0 afterwards.
- Contention: both vld held high for 8 cycles from reset -> grants alternate 0,1,0,1,...; 4 ops each; res pulses alternate starting with res0_vld at cycle LATENCY+2 after the first grant; peak inflight=8.
- Priority handoff: req1 issues alone, then both request next cycle -> req0 is granted first (pointer passed to 0).
- Streaming: req0_vld held high for 40 cycles, req1 idle -> 40 consecutive grants; 40 consecutive res0_vld pulses; results are in order with distinct angles (k*0x01000000); inflight saturates at LATENCY+2=18.
- Reset mid-flight: 5 ops issued, rst pulsed for 1 cycle at the 3rd cycle after the last issue -> no res*_vld pulse afterwards; inflight=0 and busy=0 after the reset edge; req0 priority restored.
- Idle hold: no vld for 20 cycles after one issue -> cor_* unchanged and exactly one result pulse.
